// File: rtl/cmlb_ctrl.sv
// Sequencer/arbiter for the single cmlb lookup/write port: refills, invalidates, fetch lookups
// and a set-by-set flush, plus a one-entry outstanding-miss tracker with a timeout.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | port arbitrated per cycle: flush_req > refill > inval > fetch
// FLUSH | one set cleared per cycle, all other requesters stalled
module cmlb_ctrl #(
   parameter int IP_WIDTH = 65,
   parameter int DATA_W   = 64,
   parameter int SET_BITS = 8,
   parameter int MISS_TMO = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fe_req,
   input  logic [IP_WIDTH-1:0] fe_addr,
   input  logic                fe_tr,
   output logic                fe_gnt,
   output logic                fe_fault,
   input  logic                c_hit,
   output logic                c_clkEn,
   output logic [IP_WIDTH-1:0] c_addr,
   output logic                c_tr,
   output logic                c_wen,
   output logic [DATA_W-1:0]   c_wdata,
   output logic                c_inv,
   output logic                c_flush,
   output logic [SET_BITS-1:0] c_fidx,
   output logic                miss_valid,
   output logic [IP_WIDTH-1:0] miss_addr,
   input  logic                miss_ack,
   input  logic                rf_valid,
   output logic                rf_ready,
   input  logic [IP_WIDTH-1:0] rf_addr,
   input  logic                rf_tr,
   input  logic [DATA_W-1:0]   rf_data,
   input  logic                rf_fault,
   input  logic                inv_valid,
   output logic                inv_ready,
   input  logic [IP_WIDTH-1:0] inv_addr,
   input  logic                inv_tr,
   input  logic                flush_req,
   output logic                flush_busy,
   output logic                flush_done
);

   localparam int TMO_W = $clog2(MISS_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MISS_TMO - 1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t              state;
   logic [SET_BITS-1:0] fidx;
   logic                pend;
   logic                pend_tr;
   logic [IP_WIDTH-1:0] pend_addr;
   logic [TMO_W-1:0]    tmo_cnt;

   logic idle, do_rf, do_inv, do_fe, rf_match;

   assign idle   = (state == IDLE);
   assign do_rf  = idle & ~flush_req & rf_valid;
   assign do_inv = idle & ~flush_req & ~rf_valid & inv_valid;
   assign do_fe  = idle & ~flush_req & ~rf_valid & ~inv_valid & fe_req & ~pend;

   // A refill retires the pending miss only if it is for the same page and entry type.
   assign rf_match = pend & (rf_tr == pend_tr)
                   & (rf_addr[IP_WIDTH-1:14] == pend_addr[IP_WIDTH-1:14]);

   assign fe_gnt     = do_fe;
   assign rf_ready   = do_rf;
   assign inv_ready  = do_inv;
   assign c_clkEn    = do_inv | do_fe;
   assign c_inv      = do_inv;
   assign c_wen      = do_rf & ~rf_fault;
   assign c_wdata    = do_rf ? rf_data : '0;
   assign c_flush    = (state == FLUSH);
   assign flush_busy = (state == FLUSH);
   assign c_fidx     = fidx;
   assign miss_addr  = pend_addr;

   always_comb begin
      c_addr = '0;
      c_tr   = 1'b0;
      if (do_rf) begin
         c_addr = rf_addr;
         c_tr   = rf_tr;
      end else if (do_inv) begin
         c_addr = inv_addr;
         c_tr   = inv_tr;
      end else if (do_fe) begin
         c_addr = fe_addr;
         c_tr   = fe_tr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         fidx       <= '0;
         pend       <= 1'b0;
         pend_tr    <= 1'b0;
         pend_addr  <= '0;
         tmo_cnt    <= '0;
         miss_valid <= 1'b0;
         fe_fault   <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         fe_fault   <= 1'b0;
         flush_done <= 1'b0;

         case (state)
            IDLE: begin
               if (flush_req) begin
                  state <= FLUSH;
                  fidx  <= '0;
               end
            end
            FLUSH: begin
               fidx <= fidx + 1'b1;
               if (fidx == '1) begin
                  state      <= IDLE;
                  flush_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (miss_valid && miss_ack)
            miss_valid <= 1'b0;

         // Timeout only advances in IDLE, so a flush freezes the pending miss's clock.
         if (do_rf && rf_match) begin
            pend       <= 1'b0;
            miss_valid <= 1'b0;
            fe_fault   <= rf_fault;
         end else if (pend && idle) begin
            if (tmo_cnt == '0) begin
               pend       <= 1'b0;
               miss_valid <= 1'b0;
               fe_fault   <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt - 1'b1;
            end
         end else if (do_fe && !c_hit) begin
            pend       <= 1'b1;
            pend_addr  <= fe_addr;
            pend_tr    <= fe_tr;
            miss_valid <= 1'b1;
            tmo_cnt    <= TMO_LOAD;
         end
      end
   end

endmodule

// File: tb/tb_cmlb_ctrl.sv
// Bench for cmlb_ctrl: directed scenarios followed by random traffic, every cycle compared
// against a behavioural model of the arbitration, flush walk and miss tracker.
module tb_cmlb_ctrl;

   localparam int IPW = 65;
   localparam int DW  = 64;
   localparam int SB  = 8;
   localparam int TMO = 16;
   localparam int NSETS = 2 ** SB;

   localparam int OP_NONE = 0, OP_FLUSH = 1, OP_RF = 2, OP_INV = 3, OP_FE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b0;
   logic           fe_req = 1'b0, fe_tr = 1'b0, c_hit = 1'b0, miss_ack = 1'b0;
   logic [IPW-1:0] fe_addr = '0, rf_addr = '0, inv_addr = '0;
   logic           rf_valid = 1'b0, rf_tr = 1'b0, rf_fault = 1'b0;
   logic [DW-1:0]  rf_data = '0;
   logic           inv_valid = 1'b0, inv_tr = 1'b0, flush_req = 1'b0;

   logic           fe_gnt, fe_fault, c_clkEn, c_tr, c_wen, c_inv, c_flush;
   logic [IPW-1:0] c_addr, miss_addr;
   logic [DW-1:0]  c_wdata;
   logic [SB-1:0]  c_fidx;
   logic           miss_valid, rf_ready, inv_ready, flush_busy, flush_done;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit             m_flush = 0, m_done = 0, m_fault = 0, m_pend = 0, m_tr = 0, m_mv = 0;
   int             m_fidx = 0, m_age = 0;
   logic [IPW-1:0] m_addr = '0;

   cmlb_ctrl #(.IP_WIDTH(IPW), .DATA_W(DW), .SET_BITS(SB), .MISS_TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .fe_req(fe_req), .fe_addr(fe_addr), .fe_tr(fe_tr), .fe_gnt(fe_gnt), .fe_fault(fe_fault),
      .c_hit(c_hit), .c_clkEn(c_clkEn), .c_addr(c_addr), .c_tr(c_tr), .c_wen(c_wen),
      .c_wdata(c_wdata), .c_inv(c_inv), .c_flush(c_flush), .c_fidx(c_fidx),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ack(miss_ack),
      .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_tr(rf_tr),
      .rf_data(rf_data), .rf_fault(rf_fault),
      .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_addr(inv_addr), .inv_tr(inv_tr),
      .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IPW-1:0] raddr();
      return {1'($urandom), $urandom, $urandom};
   endfunction

   // Compare all outputs mid-cycle against the model, then advance the model across the edge.
   task automatic tick();
      int             op;
      logic [IPW-1:0] ea;
      logic           et;
      bit             nf, nd, matched;
      @(negedge clk);
      op = OP_NONE;
      if (!m_flush) begin
         if (flush_req)               op = OP_FLUSH;
         else if (rf_valid)           op = OP_RF;
         else if (inv_valid)          op = OP_INV;
         else if (fe_req && !m_pend)  op = OP_FE;
      end
      ea = '0;
      et = 1'b0;
      if (op == OP_RF)       begin ea = rf_addr;  et = rf_tr;  end
      else if (op == OP_INV) begin ea = inv_addr; et = inv_tr; end
      else if (op == OP_FE)  begin ea = fe_addr;  et = fe_tr;  end
      chk("fe_gnt",     128'(fe_gnt),     128'(op == OP_FE));
      chk("rf_ready",   128'(rf_ready),   128'(op == OP_RF));
      chk("inv_ready",  128'(inv_ready),  128'(op == OP_INV));
      chk("c_clkEn",    128'(c_clkEn),    128'(op == OP_INV || op == OP_FE));
      chk("c_inv",      128'(c_inv),      128'(op == OP_INV));
      chk("c_wen",      128'(c_wen),      128'(op == OP_RF && !rf_fault));
      chk("c_wdata",    128'(c_wdata),    128'(op == OP_RF ? rf_data : '0));
      chk("c_addr",     128'(c_addr),     128'(ea));
      chk("c_tr",       128'(c_tr),       128'(et));
      chk("c_flush",    128'(c_flush),    128'(m_flush));
      chk("flush_busy", 128'(flush_busy), 128'(m_flush));
      chk("c_fidx",     128'(c_fidx),     128'(m_flush ? m_fidx : 0));
      chk("flush_done", 128'(flush_done), 128'(m_done));
      chk("fe_fault",   128'(fe_fault),   128'(m_fault));
      chk("miss_valid", 128'(miss_valid), 128'(m_mv));
      chk("miss_addr",  128'(miss_addr),  128'(m_addr));

      if (!rst) begin
         m_flush = 0; m_done = 0; m_fault = 0; m_pend = 0; m_tr = 0; m_mv = 0;
         m_fidx = 0; m_age = 0; m_addr = '0;
      end else begin
         nf = 0;
         nd = 0;
         if (m_mv && miss_ack) m_mv = 0;
         matched = (op == OP_RF) && m_pend && (rf_tr == m_tr)
                   && (rf_addr[IPW-1:14] == m_addr[IPW-1:14]);
         if (matched) begin
            m_pend = 0; m_mv = 0; nf = rf_fault;
         end else if (m_pend && !m_flush) begin
            m_age++;
            if (m_age == TMO) begin
               m_pend = 0; m_mv = 0; nf = 1;
            end
         end else if (op == OP_FE && !c_hit) begin
            m_pend = 1; m_mv = 1; m_addr = fe_addr; m_tr = fe_tr; m_age = 0;
         end
         if (m_flush) begin
            if (m_fidx == NSETS - 1) begin
               m_flush = 0; m_fidx = 0; nd = 1;
            end else begin
               m_fidx++;
            end
         end else if (op == OP_FLUSH) begin
            m_flush = 1; m_fidx = 0;
         end
         m_fault = nf;
         m_done  = nd;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fe_req = 0; c_hit = 0; miss_ack = 0; rf_valid = 0; rf_fault = 0;
      inv_valid = 0; flush_req = 0; fe_tr = 0; rf_tr = 0; inv_tr = 0;
   endtask

   initial begin
      int n, n_busy, n_rdy, n_done;

      @(posedge clk);
      #1;
      tick();
      chk("rst_busy",  128'(flush_busy), 128'(0));
      chk("rst_mv",    128'(miss_valid), 128'(0));
      chk("rst_fault", 128'(fe_fault),   128'(0));
      rst = 1;
      tick();

      // fetch hit
      fe_req = 1; fe_addr = 65'h1000; c_hit = 1;
      #1;
      chk("hit_gnt",   128'(fe_gnt),  128'(1));
      chk("hit_clken", 128'(c_clkEn), 128'(1));
      tick();
      fe_req = 0;
      chk("hit_no_miss", 128'(miss_valid), 128'(0));

      // fetch miss, walker ack, refill
      fe_req = 1; fe_addr = 65'h4000; c_hit = 0;
      tick();
      chk("miss_valid_set", 128'(miss_valid), 128'(1));
      chk("miss_addr_set",  128'(miss_addr),  128'(65'h4000));
      chk("miss_blocks",    128'(fe_gnt),     128'(0));
      tick();
      miss_ack = 1;
      tick();
      miss_ack = 0;
      chk("miss_acked", 128'(miss_valid), 128'(0));
      chk("still_blocked", 128'(fe_gnt), 128'(0));
      rf_valid = 1; rf_addr = 65'h4000; rf_data = {$urandom, $urandom};
      #1;
      chk("rf_wen",   128'(c_wen),    128'(1));
      chk("rf_ready", 128'(rf_ready), 128'(1));
      tick();
      rf_valid = 0; c_hit = 1;
      #1;
      chk("gnt_after_refill", 128'(fe_gnt), 128'(1));
      tick();
      fe_req = 0;

      // flush with refill pending throughout
      flush_req = 1; rf_valid = 1; rf_addr = 65'h8000;
      tick();
      flush_req = 0;
      n_busy = 0; n_rdy = 0;
      for (int i = 0; i < 400; i++) begin
         if (flush_done) break;
         if (flush_busy) n_busy++;
         if (flush_busy && rf_ready) n_rdy++;
         tick();
      end
      chk("flush_len",      128'(n_busy),     128'(NSETS));
      chk("flush_rf_stall", 128'(n_rdy),      128'(0));
      chk("flush_done",     128'(flush_done), 128'(1));
      chk("rf_after_flush", 128'(rf_ready),   128'(1));
      tick();
      rf_valid = 0;

      // refill, invalidate and fetch in the same cycle
      rf_valid = 1; inv_valid = 1; fe_req = 1; c_hit = 1;
      rf_addr = 65'h2000; inv_addr = 65'h2000; fe_addr = 65'h3000;
      #1;
      chk("pri_rf",  128'({rf_ready, inv_ready, fe_gnt}), 128'(3'b100));
      tick();
      rf_valid = 0;
      #1;
      chk("pri_inv", 128'({rf_ready, inv_ready, fe_gnt}), 128'(3'b010));
      tick();
      inv_valid = 0;
      #1;
      chk("pri_fe",  128'({rf_ready, inv_ready, fe_gnt}), 128'(3'b001));
      tick();
      fe_req = 0;

      // miss with no refill times out
      fe_req = 1; fe_addr = 65'h6000; c_hit = 0;
      tick();
      fe_req = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (fe_fault) break;
         n++;
         tick();
      end
      chk("tmo_len", 128'(n), 128'(TMO));
      fe_req = 1; c_hit = 1;
      #1;
      chk("tmo_gnt", 128'(fe_gnt), 128'(1));
      tick();
      fe_req = 0;

      // reset mid-flush
      flush_req = 1;
      tick();
      flush_req = 0;
      for (int i = 0; i < 300; i++) begin
         if (c_fidx == SB'(100)) break;
         tick();
      end
      chk("abort_at", 128'(c_fidx), 128'(100));
      rst = 0;
      tick();
      rst = 1;
      chk("abort_busy",  128'(flush_busy), 128'(0));
      chk("abort_flush", 128'(c_flush),    128'(0));
      n_done = 0;
      for (int i = 0; i < 300; i++) begin
         if (flush_done) n_done++;
         tick();
      end
      chk("abort_no_done", 128'(n_done), 128'(0));

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         idle_inputs();
         rst       = ($urandom_range(0, 999) != 0);
         flush_req = ($urandom_range(0, 299) == 0);
         rf_valid  = ($urandom_range(0, 5) == 0);
         inv_valid = ($urandom_range(0, 5) == 0);
         fe_req    = ($urandom_range(0, 1) == 0);
         c_hit     = ($urandom_range(0, 1) == 0);
         miss_ack  = ($urandom_range(0, 2) == 0);
         rf_fault  = ($urandom_range(0, 3) == 0);
         fe_addr   = raddr();
         fe_tr     = 1'($urandom);
         inv_addr  = raddr();
         inv_tr    = 1'($urandom);
         rf_data   = {$urandom, $urandom};
         if (m_pend && $urandom_range(0, 2) != 0) begin
            rf_addr = {m_addr[IPW-1:14], 14'($urandom)};
            rf_tr   = m_tr;
         end else begin
            rf_addr = raddr();
            rf_tr   = 1'($urandom);
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
